// File: rtl/dmx_pkg.sv
// Shared types and constants for the 1-to-8 lane demultiplexer.
// Lane vectors are ascending [0:7] so index 0 is the first lane / first serial bit.
package dmx_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(LANES - 1);

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_SEQ  = 1'b1
  } mode_e;

  typedef logic [0:LANES-1] lane_t;

endpackage

// File: rtl/dec_3x8_en.sv
// Combinational 3-to-8 one-hot decoder with enable; output bit k is lane k.
module dec_3x8_en
  import dmx_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output lane_t            onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int k = 0; k < LANES; k++) begin
      onehot_o[k] = en_i && (sel_i == SEL_W'(k));
    end
  end

endmodule

// File: rtl/demux_1x8_seq.sv
// Registered 1-to-8 demux / serial-to-parallel collector with valid/ready word output.
// Optional DMX_PARITY_EN adds a registered parity output par over the lanes.
module demux_1x8_seq
  import dmx_pkg::*;
#(
  parameter lane_t RST_VAL     = 8'h00,
  parameter bit    CLR_ON_EMIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] s,
  input  logic             d,
  input  logic             d_vld,
  output logic             d_rdy,
  output lane_t            o,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [SEL_W-1:0] ptr
`ifdef DMX_PARITY_EN
  ,
  output logic             par
`endif
);

  mode_e            mode_cur;
  logic             accept;
  logic             emit;
  logic [SEL_W-1:0] sel;
  lane_t            lane_we;
  lane_t            lane_base;
  lane_t            o_d;
  lane_t            o_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] ptr_q;
  logic             vld_d;
  logic             vld_q;

  assign mode_cur = mode_e'(mode);

  // Ready depends only on the word register, never on d_vld.
  assign d_rdy  = !vld_q || o_rdy;
  assign accept = d_vld && d_rdy;
  assign emit   = vld_q && o_rdy;

  assign sel = (mode_cur == MODE_SEQ) ? ptr_q : s;

  dec_3x8_en u_dec (
    .en_i     (accept),
    .sel_i    (sel),
    .onehot_o (lane_we)
  );

  // Lane next state: an emitted word may first be cleared, then the accepted bit overlays it.
  always_comb begin
    lane_base = o_q;
    if (CLR_ON_EMIT && emit) begin
      lane_base = RST_VAL;
    end
    o_d = lane_base;
    for (int k = 0; k < LANES; k++) begin
      if (lane_we[k]) begin
        o_d[k] = d;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (mode_cur == MODE_ADDR) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = ptr_q + SEL_W'(1);
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (emit) begin
      vld_d = 1'b0;
    end
    if ((mode_cur == MODE_SEQ) && accept && (ptr_q == PTR_LAST)) begin
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q   <= RST_VAL;
      ptr_q <= '0;
      vld_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
    end
  end

  assign o     = o_q;
  assign o_vld = vld_q;
  assign ptr   = ptr_q;

`ifdef DMX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= ^RST_VAL;
    end else begin
      par_q <= ^o_d;
    end
  end

  assign par = par_q;
`endif

`ifndef SYNTHESIS
  // A stalled word must hold its lanes and its valid flag.
  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (vld_q && !o_rdy) |=> (vld_q && $stable(o_q)));

  a_addr_ptr_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (mode_cur == MODE_ADDR) |=> (ptr_q == '0));
`endif

endmodule

// File: tb/tb_demux_1x8_seq.sv
// Directed self-checking bench for demux_1x8_seq (default parameters).
module tb_demux_1x8_seq;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [2:0] s;
  logic       d;
  logic       d_vld;
  logic       d_rdy;
  logic [0:7] o;
  logic       o_vld;
  logic       o_rdy;
  logic [2:0] ptr;
`ifdef DMX_PARITY_EN
  logic       par;
`endif

  int checks = 0;
  int errors = 0;

  demux_1x8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .s     (s),
    .d     (d),
    .d_vld (d_vld),
    .d_rdy (d_rdy),
    .o     (o),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .ptr   (ptr)
`ifdef DMX_PARITY_EN
    ,
    .par   (par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode  = 1'b0;
    s     = 3'd0;
    d     = 1'b0;
    d_vld = 1'b0;
    o_rdy = 1'b0;
    #12;
    checks++; if (o !== 8'h00) begin errors++; $display("FAIL rst_o got=%b exp=%b", o, 8'h00); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL rst_ptr got=%0d exp=0", ptr); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b exp=0", o_vld); end
    rst_n = 1'b1;
    step();
    // Mid-word reset: three bits in sequential mode, then an asynchronous pulse.
    mode  = 1'b1;
    d_vld = 1'b1;
    d     = 1'b1;
    repeat (3) step();
    d_vld = 1'b0;
    checks++; if (o !== 8'b1110_0000) begin errors++; $display("FAIL midword_o got=%b exp=%b", o, 8'b1110_0000); end
    checks++; if (ptr !== 3'd3) begin errors++; $display("FAIL midword_ptr got=%0d exp=3", ptr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o !== 8'h00) begin errors++; $display("FAIL async_rst_o got=%b exp=%b", o, 8'h00); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL async_rst_ptr got=%0d exp=0", ptr); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL async_rst_vld got=%b exp=0", o_vld); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_addressed();
    mode  = 1'b0;
    o_rdy = 1'b0;
    d_vld = 1'b1;
    s = 3'd5; d = 1'b1;
    step();
    checks++; if (o !== 8'b0000_0100) begin errors++; $display("FAIL addr_w1 got=%b exp=%b", o, 8'b0000_0100); end
    s = 3'd2; d = 1'b1;
    step();
    checks++; if (o !== 8'b0010_0100) begin errors++; $display("FAIL addr_w2 got=%b exp=%b", o, 8'b0010_0100); end
    s = 3'd5; d = 1'b0;
    step();
    checks++; if (o !== 8'b0010_0000) begin errors++; $display("FAIL addr_w3 got=%b exp=%b", o, 8'b0010_0000); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL addr_vld got=%b exp=0", o_vld); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL addr_ptr got=%0d exp=0", ptr); end
    // No accept, no lane change.
    d_vld = 1'b0; s = 3'd0; d = 1'b1;
    step();
    checks++; if (o !== 8'b0010_0000) begin errors++; $display("FAIL addr_noacc got=%b exp=%b", o, 8'b0010_0000); end
  endtask

  task automatic test_seq_word();
    logic [0:7] bits;
    bits  = 8'b1011_0010;
    mode  = 1'b1;
    o_rdy = 1'b1;
    d_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = bits[i];
      step();
      if (i == 6) begin
        checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL seq_vld_early got=%b exp=0", o_vld); end
      end
    end
    d_vld = 1'b0;
    checks++; if (o !== 8'b1011_0010) begin errors++; $display("FAIL seq_word got=%b exp=%b", o, 8'b1011_0010); end
    checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL seq_vld got=%b exp=1", o_vld); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL seq_ptr_wrap got=%0d exp=0", ptr); end
`ifdef DMX_PARITY_EN
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL par_word got=%b exp=0", par); end
`endif
    step();
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL seq_vld_once got=%b exp=0", o_vld); end
    checks++; if (o !== 8'b1011_0010) begin errors++; $display("FAIL seq_hold got=%b exp=%b", o, 8'b1011_0010); end
  endtask

`ifdef DMX_PARITY_EN
  task automatic test_parity();
    mode  = 1'b0;
    d_vld = 1'b1;
    s = 3'd1; d = 1'b1;
    step();
    d_vld = 1'b0;
    checks++; if (o !== 8'b1111_0010) begin errors++; $display("FAIL par_lane got=%b exp=%b", o, 8'b1111_0010); end
    checks++; if (par !== 1'b1) begin errors++; $display("FAIL par_addr got=%b exp=1", par); end
  endtask
`endif

  task automatic test_backpressure();
    logic [0:7] bits;
    bits  = 8'b0110_1001;
    mode  = 1'b1;
    o_rdy = 1'b0;
    d_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = bits[i];
      step();
    end
    checks++; if (o_vld !== 1'b1) begin errors++; $display("FAIL bp_vld got=%b exp=1", o_vld); end
    d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (d_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy%0d got=%b exp=0", i, d_rdy); end
      step();
      checks++; if (o !== 8'b0110_1001) begin errors++; $display("FAIL bp_stable%0d got=%b exp=%b", i, o, 8'b0110_1001); end
      checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL bp_ptr%0d got=%0d exp=0", i, ptr); end
    end
    o_rdy = 1'b1;
    #1;
    checks++; if (d_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_release got=%b exp=1", d_rdy); end
    step();
    d_vld = 1'b0;
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL bp_xfer_vld got=%b exp=0", o_vld); end
    checks++; if (o !== 8'b1110_1001) begin errors++; $display("FAIL bp_xfer_o got=%b exp=%b", o, 8'b1110_1001); end
    checks++; if (ptr !== 3'd1) begin errors++; $display("FAIL bp_xfer_ptr got=%0d exp=1", ptr); end
  endtask

  task automatic test_mode_change();
    logic [0:4] bits;
    bits  = 5'b11011;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mode  = 1'b1;
    o_rdy = 1'b0;
    s     = 3'd7;
    d_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = bits[i];
      step();
    end
    d_vld = 1'b0;
    checks++; if (o !== 8'b1101_1000) begin errors++; $display("FAIL mc_partial got=%b exp=%b", o, 8'b1101_1000); end
    checks++; if (ptr !== 3'd5) begin errors++; $display("FAIL mc_ptr5 got=%0d exp=5", ptr); end
    mode = 1'b0;
    #1;
    checks++; if (ptr !== 3'd5) begin errors++; $display("FAIL mc_ptr_reg got=%0d exp=5", ptr); end
    step();
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL mc_ptr_clr got=%0d exp=0", ptr); end
    checks++; if (o !== 8'b1101_1000) begin errors++; $display("FAIL mc_kept got=%b exp=%b", o, 8'b1101_1000); end
    s = 3'd7; d = 1'b1; d_vld = 1'b1;
    step();
    d_vld = 1'b0;
    checks++; if (o !== 8'b1101_1001) begin errors++; $display("FAIL mc_s7 got=%b exp=%b", o, 8'b1101_1001); end
    checks++; if (o_vld !== 1'b0) begin errors++; $display("FAIL mc_vld got=%b exp=0", o_vld); end
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_seq_word();
`ifdef DMX_PARITY_EN
    test_parity();
`endif
    test_backpressure();
    test_mode_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
